// File: rtl/cam_ctrl_if.sv
// Request/response handshake bundle for the CAM command front-end.
// master: issues req_*, consumes rsp_*; slave: the cam_ctrl side.
interface cam_ctrl_if #(
    parameter int CAM_WIDTH = 32,
    parameter int CAM_DEPTH = 16
);
    localparam int IDX_W = $clog2(CAM_DEPTH);

    logic                 req_valid;
    logic                 req_ready;
    logic [1:0]           req_op;
    logic [CAM_WIDTH-1:0] req_key;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic                 rsp_hit;
    logic [IDX_W-1:0]     rsp_idx;
    logic                 rsp_evict;

    modport master (
        output req_valid, req_op, req_key, rsp_ready,
        input  req_ready, rsp_valid, rsp_hit, rsp_idx, rsp_evict
    );

    modport slave (
        input  req_valid, req_op, req_key, rsp_ready,
        output req_ready, rsp_valid, rsp_hit, rsp_idx, rsp_evict
    );
endinterface

// File: rtl/cam_ctrl.sv
// CAM command front-end: serialises LOOKUP/INSERT/DELETE into search
// and write cycles, tracks occupancy, allocates free or victim slots.
// Ports: clk, rst (sync, active-high); bus (cam_ctrl_if.slave) carries
// req_*/rsp_*; cam_data_* drive the CAM write/search port; cam_index_*
// return the CAM match; occ_count/full report occupancy.
module cam_ctrl #(
    parameter int   CAM_WIDTH = 32,
    parameter int   CAM_DEPTH = 16,
    localparam int  IDX_W     = $clog2(CAM_DEPTH),
    localparam int  CNT_W     = $clog2(CAM_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    cam_ctrl_if.slave            bus,
    output logic                 cam_data_we,
    output logic [IDX_W-1:0]     cam_data_idx,
    output logic [CAM_WIDTH-1:0] cam_data_o,
    output logic                 cam_data_vld,
    input  logic                 cam_index_rdy,
    input  logic [IDX_W-1:0]     cam_index_i,
    output logic [CNT_W-1:0]     occ_count,
    output logic                 full
);
    typedef enum logic [1:0] {
        IDLE, SEARCH, WRITE, RESP
    } state_t;

    state_t               state, state_nx;
    logic [1:0]           op_q;
    logic [CAM_WIDTH-1:0] key_q;
    logic                 hit_q, evict_q;
    logic [IDX_W-1:0]     idx_q;
    logic [CAM_DEPTH-1:0] occupied;
    logic [IDX_W-1:0]     victim;
    logic [IDX_W-1:0]     free_idx;
    logic                 is_ins, is_del;
    logic                 s_hit, s_evict, s_write;
    logic [IDX_W-1:0]     s_idx;

    // Reserved opcode 3 falls through to LOOKUP.
    assign is_ins = (op_q == 2'd1);
    assign is_del = (op_q == 2'd2);
    assign full   = (occ_count == CNT_W'(CAM_DEPTH));

    // Lowest clear bit of occupied[]; only consulted when not full.
    always_comb begin
        free_idx = '0;
        for (int i = CAM_DEPTH - 1; i >= 0; i--) begin
            if (!occupied[i]) free_idx = IDX_W'(i);
        end
    end

    // Outcome of the search cycle, latched at the end of SEARCH.
    always_comb begin
        s_hit   = cam_index_rdy;
        s_idx   = cam_index_rdy ? cam_index_i : '0;
        s_evict = 1'b0;
        s_write = 1'b0;
        if (is_ins && !cam_index_rdy) begin
            s_idx   = full ? victim : free_idx;
            s_evict = full;
            s_write = 1'b1;
        end else if (is_del && cam_index_rdy) begin
            s_write = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.req_valid) state_nx = SEARCH;
            SEARCH:  state_nx = s_write ? WRITE : RESP;
            WRITE:   state_nx = RESP;
            RESP:    if (bus.rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = (state == IDLE);
        bus.rsp_valid = (state == RESP);
        bus.rsp_hit   = hit_q;
        bus.rsp_idx   = idx_q;
        bus.rsp_evict = evict_q;
        cam_data_o    = key_q;
        cam_data_we   = (state == WRITE);
        cam_data_idx  = (state == WRITE) ? idx_q : '0;
        cam_data_vld  = (state == WRITE) && is_ins;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= '0;
            key_q     <= '0;
            hit_q     <= 1'b0;
            idx_q     <= '0;
            evict_q   <= 1'b0;
            occupied  <= '0;
            occ_count <= '0;
            victim    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        op_q    <= bus.req_op;
                        key_q   <= bus.req_key;
                        hit_q   <= 1'b0;
                        idx_q   <= '0;
                        evict_q <= 1'b0;
                    end
                end
                SEARCH: begin
                    hit_q   <= s_hit;
                    idx_q   <= s_idx;
                    evict_q <= s_evict;
                end
                WRITE: begin
                    if (is_ins) begin
                        occupied[idx_q] <= 1'b1;
                        // Eviction swaps one entry for another.
                        if (evict_q) victim <= victim + IDX_W'(1);
                        else occ_count <= occ_count + CNT_W'(1);
                    end else begin
                        occupied[idx_q] <= 1'b0;
                        occ_count <= occ_count - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/cam_ctrl.md
Name: cam_ctrl

Overview:
- Command front-end that sits directly upstream of the CAM array and owns its write/search port.
- Accepts LOOKUP / INSERT / DELETE requests over a valid/ready handshake and serialises each into a search cycle plus an optional write cycle on the CAM.
- Tracks entry occupancy internally and allocates slots on INSERT: lowest free index first, round-robin eviction when the CAM is full.
- Returns hit/index/evict results over a valid/ready response channel.

Parameters:
- CAM_WIDTH, 32, key width; must equal the CAM array's CAM_WIDTH.
- CAM_DEPTH, 16, number of entries; must equal the CAM array's CAM_DEPTH; power of two, >= 2.
- IDX_W (localparam), $clog2(CAM_DEPTH), index width.
- CNT_W (localparam), $clog2(CAM_DEPTH+1), occupancy count width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when req_valid && req_ready
- req_op  in  2  0=LOOKUP, 1=INSERT, 2=DELETE, 3=reserved (treated as LOOKUP)
- req_key  in  CAM_WIDTH  key
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_hit  out  1  key was present at search time
- rsp_idx  out  IDX_W  matched or allocated index
- rsp_evict  out  1  INSERT overwrote an occupied entry
- cam_data_we  out  1  CAM write enable
- cam_data_idx  out  IDX_W  CAM write index
- cam_data_o  out  CAM_WIDTH  CAM key bus (used for both compare and write)
- cam_data_vld  out  1  valid bit written with the entry
- cam_index_rdy  in  1  CAM any-match (combinational from cam_data_o)
- cam_index_i  in  IDX_W  CAM lowest matching index
- occ_count  out  CNT_W  number of occupied entries
- full  out  1  occ_count == CAM_DEPTH

Behaviour:
- FSM states: IDLE, SEARCH, WRITE, RESP.
- req_ready = (state==IDLE). On accept, op and key are registered and the FSM moves to SEARCH.
- SEARCH (1 cycle):
  - cam_data_o = key, cam_data_we = 0; cam_index_rdy / cam_index_i are sampled at the end of the cycle.
  - LOOKUP: -> RESP, hit = cam_index_rdy, idx = cam_index_i (idx = 0 on miss).
  - INSERT hit: -> RESP, hit = 1, idx = match, no write.
  - INSERT miss: allocate. If not full, idx = lowest clear bit of occupied[], evict = 0. If full, idx = victim pointer, evict = 1. -> WRITE.
  - DELETE hit: idx = match -> WRITE. DELETE miss: -> RESP, hit = 0, idx = 0.
- WRITE (1 cycle):
  - cam_data_we = 1, cam_data_idx = idx, cam_data_o = key.
  - cam_data_vld = 1 for INSERT, 0 for DELETE.
  - occupied[idx] is set or cleared; occ_count is updated in the same edge (unchanged on eviction). -> RESP.
- Victim pointer:
  - Reset 0. Increments mod CAM_DEPTH only on an evicting INSERT.
  - Free-slot allocation does not move it.
- RESP:
  - rsp_valid = 1; all rsp_* fields are held stable until rsp_ready.
  - On handshake -> IDLE. req_ready rises in the following cycle; there is no same-cycle bypass.
- Latency, accept edge to rsp_valid: LOOKUP, INSERT-hit and DELETE-miss = 2 cycles; INSERT-miss and DELETE-hit = 3 cycles. Minimum op spacing is 3 or 4 cycles respectively.
- Outside WRITE: cam_data_we = 0, cam_data_vld = 0, cam_data_idx = 0. cam_data_o holds the registered key at all times.
- Reset:
  - State IDLE, occupied[] = 0, occ_count = 0, full = 0, victim = 0.
  - All rsp_* = 0, rsp_valid = 0, cam_data_we = 0.
  - rst mid-operation aborts the op with no response. The CAM array shares rst, so both sides are cleared consistently.
- req_* inputs are ignored outside IDLE.
- occupied[] must always equal the set of CAM entries with vld=1; no other agent writes the CAM.

Test Plan:
- (CAM_DEPTH=4) Reset, LOOKUP key 0xA5 -> rsp_valid 2 cycles after accept, hit=0, idx=0, occ_count=0, cam_data_we never asserted.
- INSERT 0x11, 0x22, 0x33 -> hit=0, idx=0,1,2, evict=0, occ_count=3. Then LOOKUP 0x22 -> hit=1, idx=1.
- INSERT 0x22 again -> hit=1, idx=1, no cam_data_we pulse, occ_count stays 3.
- Fill with 0x44 (idx 3, full=1). INSERT 0x55 -> evict=1, idx=0. INSERT 0x66 -> evict=1, idx=1. LOOKUP 0x11 -> hit=0. occ_count=4 throughout.
- DELETE 0x33 -> hit=1, idx=2, one-cycle write with cam_data_vld=0, occ_count=3, full=0. Next INSERT 0x77 -> idx=2, evict=0. DELETE 0x99 -> hit=0, no write.
- Hold rsp_ready=0 for 5 cycles -> rsp_* stable, req_ready=0. Assert rst during WRITE of an INSERT -> next cycle state IDLE, occ_count=0, no rsp_valid; a following LOOKUP of that key -> hit=0.
